// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready request front end for a 32x8 single-port RAM.
// Sequences single-cycle writes and latency-aware reads, returns read data
// with a one-cycle valid pulse, and sweeps the RAM to CLEAR_VAL after reset
// or on command so its contents are known before first use.
module ram_req_ctrl #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              clr_req,
  output logic              init_busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // Two bits cover the supported read latencies of 1..3 cycles.
  localparam int                WCNT_W    = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  // State and datapath registers; reset restarts a full clear sweep.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic: sweep counting, request capture and read completion.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        // A clear command wins over a pending request, which stays unaccepted.
        if (clr_req) begin
          state_d = S_CLEAR;
        end else if (req_valid && req_ready) begin
          addr_d  = req_addr;
          data_d  = req_data;
          state_d = req_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_RD: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          rsp_data_d  = ram_q;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // RAM-side outputs decoded from the registered state; only req_ready sees clr_req.
  always_comb begin
    ram_address = addr_q;
    ram_data    = data_q;
    ram_wren    = 1'b0;
    init_busy   = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        ram_address = clr_cnt_q;
        ram_data    = CLEAR_VAL;
        ram_wren    = 1'b1;
        init_busy   = 1'b1;
      end
      S_IDLE: begin
        req_ready = !clr_req;
      end
      S_WR: begin
        ram_wren = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Request controller sitting directly upstream of the 32x8 single-port RAMlpm instance; drives its address, data and wren ports and consumes q.
- Converts a valid/ready request interface (switch/CPU side) into correctly timed RAM accesses and returns read data with a one-cycle valid pulse.
- Runs an automatic clear sweep of the whole RAM after reset or on command, so the memory contents are known before first use.

Parameters:
ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W
DATA_W, 8, RAM word width
RD_LAT, 1, cycles from the RAM sampling the address to q being valid (1..3)
CLEAR_VAL, 8'h00, word written to every location during a clear sweep

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts the request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_data  in  DATA_W  write data
clr_req  in  1  start a clear sweep; sampled only in IDLE
init_busy  out  1  clear sweep in progress
rsp_valid  out  1  one-cycle pulse; rsp_data is valid
rsp_data  out  DATA_W  read result, held until the next read completes
ram_address  out  ADDR_W  to RAM address
ram_data  out  DATA_W  to RAM data
ram_wren  out  1  to RAM wren
ram_q  in  DATA_W  from RAM q

Behaviour:
- Interface: one clock and one reset only. resetn is synchronous and active-low; it is sampled on the rising edge of clock and has priority over everything.
- Reset state: state = CLEAR, clr_cnt = 0, addr_r = 0, data_r = 0, wait_cnt = 0, rsp_valid = 0, rsp_data = 0.
- Output decode: RAM-side outputs and req_ready are decoded from the registered state only, with no input-to-output paths except req_ready, which also depends on clr_req.
- States:
  - CLEAR: ram_address = clr_cnt, ram_data = CLEAR_VAL, ram_wren = 1, init_busy = 1, req_ready = 0. clr_cnt increments each cycle. At clr_cnt == DEPTH-1 go to IDLE and reset clr_cnt to 0. A sweep lasts exactly DEPTH cycles and clr_cnt does not wrap past the sweep.
  - IDLE: ram_wren = 0, ram_address = addr_r, ram_data = data_r, init_busy = 0, req_ready = !clr_req.
    - clr_req = 1: go to CLEAR. clr_req has priority over req_valid, and that request is not accepted.
    - Otherwise, on req_valid & req_ready: capture req_addr, req_data and req_write into registers, then go to WR if req_write = 1, else RD.
  - WR: ram_address = addr_r, ram_data = data_r, ram_wren = 1 for exactly one cycle, req_ready = 0. Next state IDLE. No response is produced.
  - RD: ram_address = addr_r, ram_wren = 0, req_ready = 0. The RAM samples the address at the end of this cycle. Next state WAIT with wait_cnt = 0.
  - WAIT: ram_address held at addr_r, ram_wren = 0. wait_cnt increments each cycle. On the edge ending the cycle where wait_cnt == RD_LAT-1: rsp_data <= ram_q, rsp_valid <= 1, state <= IDLE.
- rsp_valid: high for exactly one cycle, the first IDLE cycle after WAIT. A new request may be accepted in that same cycle.
- Latency with RD_LAT = 1:
  - Read: accept edge E0; rsp_valid is high in the cycle after edge E0+2.
  - Write: RAM write occurs at edge E0+1.
  - Back-to-back sustained rate: one write per 2 cycles, one read per 3 cycles.
- Boundary conditions:
  - Address DEPTH-1 is handled like any other address, with no wrap arithmetic on request addresses.
  - Requests during CLEAR, WR, RD or WAIT see req_ready = 0. The requester must hold req_valid and its payload stable until accepted.
  - resetn low mid-operation: any in-flight write or read is abandoned, no rsp_valid is issued, and a full clear sweep restarts.
  - clr_req asserted outside IDLE is ignored; it is not latched.
  - A write to address A followed immediately by a read of A returns the new data.

Test Plan:
- Release resetn -> init_busy = 1 and ram_wren = 1 for exactly 32 cycles with ram_address stepping 0..31; then req_ready = 1; reads of addresses 0, 17 and 31 return 8'h00.
- Write 8'hA5 to addr 3 (accepted at E0), then read addr 3 -> ram_wren high only in the cycle after E0; rsp_valid pulses once, 3 cycles after the read accept, with rsp_data = 8'hA5.
- Back-to-back: write 8'h3C to addr 31, read addr 31, read addr 0 with req_valid held high -> accepts 2 cycles apart (write to read) and 3 cycles apart (read to read); responses 8'h3C then 8'h00 in order.
- req_valid = 1 with a write to addr 5 asserted during the clear sweep -> not accepted until the first IDLE cycle; the sweep is not disturbed; a later read of addr 5 returns the written value.
- clr_req = 1 together with req_valid = 1 in IDLE -> request not accepted; a 32-cycle sweep runs; a later read of a previously written address returns CLEAR_VAL.
- resetn = 0 for 1 cycle in the WAIT state of a read -> no rsp_valid pulse; rsp_data = 0; a new 32-cycle clear sweep begins.
